game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
Game-sequencing controller for the Pong datapath, one level above the ball block.
- Owns the match flow: idle, serve countdown, live play, post-point pause, game over.
- Holds or releases the ball and keeps both players' scores from the ball's score1/score2 pulses.
- Outputs drive the ball reset/enable and the score display logic.

Parameters:
WIN_SCORE, 7, points needed to win; legal range 1..15.
SERVE_FRAMES, 60, frame ticks the ball is held at serve before release; legal range 1..255.
POINT_FRAMES, 90, frame ticks the ball is frozen after a point; legal range 1..255.

Ports:
clk  input  1  100 MHz system clock.
reset  input  1  asynchronous, active-low reset; low = reset asserted.
x  input  10  VGA pixel column from the VGA controller.
y  input  10  VGA pixel row from the VGA controller.
start  input  1  start/serve button, level, already debounced.
score1  input  1  single-cycle pulse from the ball block: player 1 scored.
score2  input  1  single-cycle pulse from the ball block: player 2 scored.
ball_hold  output  1  1 = keep the ball in reset (centre position).
ball_en  output  1  1 = ball is allowed to move.
score_p1  output  4  player 1 score.
score_p2  output  4  player 2 score.
serve_dir  output  1  0 = serve toward player 1 side; 1 = serve toward player 2 side.
game_over  output  1  high while in OVER.
winner  output  1  0 = player 1 won, 1 = player 2 won; valid only when game_over = 1.
state  output  3  current state: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.

Behaviour:
- Frame tick: frame_tick = (y == 481 && x == 0), combinational. All delay counting uses frame_tick only.
- Start edge: start_q is registered from start; start_rise = start & ~start_q. Only start_rise is acted on.
- Reset (reset low, async): state = IDLE, score_p1 = score_p2 = 0, serve_dir = 0, winner = 0, frame counter = 0, start_q = 0.
- Output decode (combinational from the state register, no extra latency):
  - ball_hold = 1 in every state except PLAY.
  - ball_en = 1 only in PLAY.
  - game_over = 1 only in OVER.
- Reset-time outputs: ball_hold = 1, ball_en = 0, game_over = 0.
- IDLE:
  - start_rise -> SERVE.
  - Scores cleared to 0 and frame counter cleared on that edge.
- SERVE:
  - Counter increments on each frame_tick.
  - On the SERVE_FRAMES-th frame_tick -> PLAY, counter cleared.
- PLAY:
  - score1 & ~score2 -> score_p1 += 1, serve_dir = 1, -> POINT.
  - score2 & ~score1 -> score_p2 += 1, serve_dir = 0, -> POINT.
  - score1 & score2 together -> ignored, stay in PLAY.
  - If the new score equals WIN_SCORE -> OVER instead of POINT; winner = scoring player.
  - Score update and state change happen on the same edge as the pulse.
- POINT:
  - Counter increments on each frame_tick.
  - After POINT_FRAMES frame_ticks the delay is complete; the exit rule depends on AUTO_SERVE_EN (see below).
- OVER:
  - Scores and winner held.
  - start_rise -> IDLE, scores cleared to 0 on that edge.
- score1/score2 pulses are ignored in every state except PLAY.
- Scores never exceed WIN_SCORE.
- Counters are 8 bits. frame_tick during the transition cycle counts toward the new state only if it arrives after entry.
- Reset mid-operation: immediate return to IDLE with all registers at reset values.

Optional Feature:
AUTO_SERVE_EN
- Defined: POINT -> SERVE automatically on the POINT_FRAMES-th frame_tick; start is ignored in POINT.
- Undefined: once the POINT delay completes, the block stays in POINT (ball held) until start_rise, then -> SERVE.
- Undefined: start_rise that arrives before the delay completes is ignored.

Test Plan:
- Reset low with start = 1 -> state = 0, ball_hold = 1, ball_en = 0, scores = 0, game_over = 0; after release, no SERVE until start toggles 0 -> 1.
- start_rise in IDLE, then 60 frame_ticks (y = 481, x = 0 for one cycle each) -> state = SERVE for ticks 1..59, PLAY on the cycle after tick 60, ball_en = 1.
- In PLAY, one-cycle score1 pulse -> score_p1 = 1, serve_dir = 1, state = POINT; with AUTO_SERVE_EN, SERVE after 90 ticks; without it, POINT is held until start_rise.
- Score 7 points for player 2 -> on the 7th score2 pulse state = OVER, game_over = 1, winner = 1, score_p2 = 7; start_rise -> IDLE, scores = 0.
- score1 and score2 in the same PLAY cycle -> both scores unchanged, state stays PLAY; score1 pulse in SERVE -> ignored.
- reset asserted mid-PLAY with score_p1 = 3 -> asynchronously state = IDLE, score_p1 = 0, ball_hold = 1 before the next clk edge.

Source files
------------

// File: rtl/game_ctrl.sv
// Pong match sequencer: serve countdown, live play, post-point pause, game over, scores.
// Optional AUTO_SERVE_EN: define it to leave the post-point pause without a start press.
module game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       start,
  input  logic       score1,
  input  logic       score2,
  output logic       ball_hold,
  output logic       ball_en,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [3:0] p1_reg, p1_next, p2_reg, p2_next;
  logic       sd_reg, sd_next;
  logic       win_reg, win_next;
  logic       start_q_reg;
  logic       armed_reg;
  logic       frame_tick, start_rise;
  logic [3:0] p1_inc, p2_inc;

  assign frame_tick = (y == 10'd481) && (x == 10'd0);
  // A start button already held through reset must be released before it can count as a press.
  assign start_rise = start & ~start_q_reg & armed_reg;
  assign p1_inc     = p1_reg + 4'd1;
  assign p2_inc     = p2_reg + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= 8'd0;
      p1_reg      <= 4'd0;
      p2_reg      <= 4'd0;
      sd_reg      <= 1'b0;
      win_reg     <= 1'b0;
      start_q_reg <= 1'b0;
      armed_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      p1_reg      <= p1_next;
      p2_reg      <= p2_next;
      sd_reg      <= sd_next;
      win_reg     <= win_next;
      start_q_reg <= start;
      armed_reg   <= armed_reg | ~start;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    p1_next    = p1_reg;
    p2_next    = p2_reg;
    sd_next    = sd_reg;
    win_next   = win_reg;
    case (state_reg)
      IDLE: begin
        if (start_rise) begin
          state_next = SERVE;
          cnt_next   = 8'd0;
          p1_next    = 4'd0;
          p2_next    = 4'd0;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (cnt_reg == SERVE_LAST) begin
            state_next = PLAY;
            cnt_next   = 8'd0;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
      PLAY: begin
        if (score1 && !score2) begin
          p1_next    = p1_inc;
          sd_next    = 1'b1;
          cnt_next   = 8'd0;
          state_next = POINT;
          if (p1_inc == WIN) begin
            state_next = OVER;
            win_next   = 1'b0;
          end
        end else if (score2 && !score1) begin
          p2_next    = p2_inc;
          sd_next    = 1'b0;
          cnt_next   = 8'd0;
          state_next = POINT;
          if (p2_inc == WIN) begin
            state_next = OVER;
            win_next   = 1'b1;
          end
        end
      end
      POINT: begin
`ifdef AUTO_SERVE_EN
        if (frame_tick) begin
          if (cnt_reg == 8'(POINT_FRAMES - 1)) begin
            state_next = SERVE;
            cnt_next   = 8'd0;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
`else
        // Counter parks at POINT_FRAMES once the pause is over; only then does start serve.
        if (cnt_reg == 8'(POINT_FRAMES)) begin
          if (start_rise) begin
            state_next = SERVE;
            cnt_next   = 8'd0;
          end
        end else if (frame_tick) begin
          cnt_next = cnt_reg + 8'd1;
        end
`endif
      end
      OVER: begin
        if (start_rise) begin
          state_next = IDLE;
          p1_next    = 4'd0;
          p2_next    = 4'd0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ball_hold = (state_reg != PLAY);
  assign ball_en   = (state_reg == PLAY);
  assign game_over = (state_reg == OVER);
  assign score_p1  = p1_reg;
  assign score_p2  = p2_reg;
  assign serve_dir = sd_reg;
  assign winner    = win_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: expected output vectors are queued as stimulus is driven
// and popped/compared one cycle later.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x, y;
  logic       start, score1, score2;
  logic       ball_hold, ball_en, serve_dir, game_over, winner;
  logic [3:0] score_p1, score_p2;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] m_state;
  logic [3:0] m_p1, m_p2;
  logic       m_sd, m_w;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  game_ctrl dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .start(start),
    .score1(score1), .score2(score2),
    .ball_hold(ball_hold), .ball_en(ball_en),
    .score_p1(score_p1), .score_p2(score_p2),
    .serve_dir(serve_dir), .game_over(game_over), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (state,p1,p2,dir,over,win,hold,en)", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dut_obs();
    return {state, score_p1, score_p2, serve_dir, game_over, game_over & winner, ball_hold, ball_en};
  endfunction

  function automatic logic [15:0] model_obs();
    logic go;
    go = (m_state == 3'd4);
    return {m_state, m_p1, m_p2, m_sd, go, go & m_w, m_state != 3'd2, m_state == 3'd2};
  endfunction

  task automatic push(input string tag);
    exp_q.push_back(model_obs());
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    logic [15:0] e;
    string t;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", dut_obs(), ~dut_obs());
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, dut_obs(), e);
    end
  endtask

  task automatic cycle(input string tag, input bit tk, input bit s1, input bit s2, input bit st);
    y      = tk ? 10'd481 : 10'd0;
    x      = 10'd0;
    score1 = s1;
    score2 = s2;
    start  = st;
    push(tag);
    @(posedge clk);
    #1;
    pop_check();
    y      = 10'd0;
    score1 = 1'b0;
    score2 = 1'b0;
  endtask

  task automatic serve_phase();
    for (int i = 1; i <= 60; i++) begin
      m_state = (i == 60) ? 3'd2 : 3'd1;
      cycle((i == 60) ? "serve_release" : "serve_tick", 1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic point_phase();
    for (int i = 1; i <= 90; i++) begin
      if (i == 45) begin
        m_state = 3'd3;
        cycle("point_early_start", 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("point_early_low", 1'b0, 1'b0, 1'b0, 1'b0);
      end
`ifdef AUTO_SERVE_EN
      m_state = (i == 90) ? 3'd1 : 3'd3;
`else
      m_state = 3'd3;
`endif
      cycle("point_tick", 1'b1, 1'b0, 1'b0, 1'b0);
    end
`ifndef AUTO_SERVE_EN
    m_state = 3'd3;
    cycle("point_hold", 1'b1, 1'b0, 1'b0, 1'b0);
    m_state = 3'd1;
    cycle("point_start", 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("point_start_low", 1'b0, 1'b0, 1'b0, 1'b0);
`endif
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; x = '0; y = '0; score1 = 1'b0; score2 = 1'b0;
    m_state = 3'd0; m_p1 = 4'd0; m_p2 = 4'd0; m_sd = 1'b0; m_w = 1'b0;
    #1 reset = 1'b0;
    #2;
    push("reset_async");
    pop_check();
    repeat (2) @(posedge clk);
    #1;
    push("reset_held");
    pop_check();
    reset = 1'b1;

    // start held high through reset: no serve until it goes low then high
    for (int i = 0; i < 3; i++) cycle("idle_start_held", 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("idle_start_low", 1'b0, 1'b0, 1'b0, 1'b0);
    m_state = 3'd1;
    cycle("idle_start_rise", 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("serve_start_high", 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("serve_score1_ign", 1'b0, 1'b1, 1'b0, 1'b0);
    serve_phase();

    cycle("play_both_ign", 1'b0, 1'b1, 1'b1, 1'b0);
    cycle("play_tick", 1'b1, 1'b0, 1'b0, 1'b0);
    m_p1 = 4'd1; m_sd = 1'b1; m_state = 3'd3;
    cycle("play_p1", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("point_score2_ign", 1'b0, 1'b0, 1'b1, 1'b0);
    point_phase();
    serve_phase();

    // player 2 runs out the game
    for (int k = 1; k <= 7; k++) begin
      m_p2 = 4'(k); m_sd = 1'b0;
      m_state = (k == 7) ? 3'd4 : 3'd3;
      m_w = 1'b1;
      cycle((k == 7) ? "play_p2_win" : "play_p2", 1'b0, 1'b0, 1'b1, 1'b0);
      if (k < 7) begin
        point_phase();
        serve_phase();
      end
    end
    cycle("over_score1_ign", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("over_hold", 1'b1, 1'b0, 1'b0, 1'b0);
    m_state = 3'd0; m_p1 = 4'd0; m_p2 = 4'd0;
    cycle("over_restart", 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("idle_after_over", 1'b0, 1'b0, 1'b0, 1'b0);

    m_state = 3'd1;
    cycle("idle_start2", 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("serve_start2_low", 1'b0, 1'b0, 1'b0, 1'b0);
    serve_phase();
    for (int k = 1; k <= 3; k++) begin
      m_p1 = 4'(k); m_sd = 1'b1; m_state = 3'd3;
      cycle("play_p1_b", 1'b0, 1'b1, 1'b0, 1'b0);
      point_phase();
      serve_phase();
    end

    // asynchronous reset in the middle of a PLAY cycle
    reset = 1'b0;
    #1;
    m_state = 3'd0; m_p1 = 4'd0; m_p2 = 4'd0; m_sd = 1'b0; m_w = 1'b0;
    push("reset_mid_play");
    pop_check();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
